// File: rtl/store_fmt3264_if.sv
`default_nettype none
// ============================================================================
// Module      : store_fmt3264_if
// Description : Handshake/bus bundle for the store write formatter.
//               Request side: req_valid/req_ready, req_addr, req_size, req_data.
//               Write side  : wr_valid/wr_ready, wr_addr, wr_data, wr_bwe,
//                             wr_last, plus the err reject pulse.
//               modport master : the store client / write consumer.
//               modport slave  : the formatter itself.
// Revision    : 1.0  initial release
// ============================================================================
interface store_fmt3264_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [28:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_bwe;
    logic        wr_last;
    logic        err;

    modport master (
        output req_valid, req_addr, req_size, req_data, wr_ready,
        input  req_ready, wr_valid, wr_addr, wr_data, wr_bwe, wr_last, err
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_data, wr_ready,
        output req_ready, wr_valid, wr_addr, wr_data, wr_bwe, wr_last, err
    );
endinterface
`default_nettype wire

// File: rtl/store_fmt3264.sv
`default_nettype none
// ============================================================================
// Module      : store_fmt3264
// Description : Formats a 32-bit big-endian store (byte/half/word, any byte
//               address) into 64-bit doubleword write beats with per-byte
//               write enables. Value byte i (most significant first) lands
//               on lane addr[2:0]+i, matching the read formatter's lanes.
//               One-beat registered output with valid/ready on both sides.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               bus   - store_fmt3264_if.slave (request + write beat + err)
// Config      : STORE_FMT_SPLIT_EN - when defined, stores that straddle a
//               doubleword boundary issue two beats; otherwise they are
//               rejected with an err pulse.
// Revision    : 1.0  initial release
// ============================================================================
module store_fmt3264 (
    input  wire logic           clk,
    input  wire logic           reset,
    store_fmt3264_if.slave      bus
);

`ifdef STORE_FMT_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1
    } state_t;
`endif

    state_t      r_state;
    logic        r_wr_valid;
    logic        r_wr_last;
    logic [28:0] r_wr_addr;
    logic [63:0] r_wr_data;
    logic [7:0]  r_wr_bwe;
    logic        r_err;

`ifdef STORE_FMT_SPLIT_EN
    // Second beat of a crossing store, parked until the first is consumed.
    logic [28:0] r_b1_addr;
    logic [63:0] r_b1_data;
    logic [7:0]  r_b1_bwe;
    logic [6:0]  w_b1_sh;
    logic [63:0] w_b1_data;
    logic [7:0]  w_b1_bwe;
`endif

    logic [2:0]  w_off;
    logic [3:0]  w_nbytes;
    logic [31:0] w_lanes;     // value bytes in lane order starting at lane 0
    logic [3:0]  w_mask;
    logic        w_cross;
    logic        w_illegal;
    logic [63:0] w_b0_data;
    logic [7:0]  w_b0_bwe;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_beat_done;

    // Byte-reverse the right-justified value so the most significant value
    // byte sits in the lowest lane; a lane shift by the offset then places it.
    always_comb begin
        w_off    = bus.req_addr[2:0];
        w_nbytes = 4'd4;
        w_lanes  = 32'd0;
        w_mask   = 4'b0000;
        case (bus.req_size)
            2'b00: begin
                w_nbytes = 4'd1;
                w_lanes  = {24'd0, bus.req_data[7:0]};
                w_mask   = 4'b0001;
            end
            2'b01: begin
                w_nbytes = 4'd2;
                w_lanes  = {16'd0, bus.req_data[7:0], bus.req_data[15:8]};
                w_mask   = 4'b0011;
            end
            2'b10: begin
                w_nbytes = 4'd4;
                w_lanes  = {bus.req_data[7:0], bus.req_data[15:8],
                            bus.req_data[23:16], bus.req_data[31:24]};
                w_mask   = 4'b1111;
            end
            default: begin
                w_nbytes = 4'd4;
                w_lanes  = 32'd0;
                w_mask   = 4'b0000;
            end
        endcase

        w_cross   = ({1'b0, w_off} + w_nbytes) > 4'd8;
`ifdef STORE_FMT_SPLIT_EN
        w_illegal = (bus.req_size == 2'b11);
`else
        w_illegal = (bus.req_size == 2'b11) || w_cross;
`endif

        // Lanes that fall past lane 7 are shifted out of the 64-bit beat.
        w_b0_data = {32'd0, w_lanes} << {w_off, 3'b000};
        w_b0_bwe  = {4'd0, w_mask} << w_off;

`ifdef STORE_FMT_SPLIT_EN
        // Lanes 8.. of the store become lanes 0.. of the next doubleword.
        // Offsets 0..4 shift by 32 or more, leaving an empty second beat.
        w_b1_sh   = 7'd64 - {1'b0, w_off, 3'b000};
        w_b1_data = {32'd0, w_lanes >> w_b1_sh};
        w_b1_bwe  = {4'd0, w_mask >> (4'd8 - {1'b0, w_off})};
`endif
    end

    // A new request may be taken when idle, or on the same edge the final
    // beat of the current store is handed off (no bubble).
    assign w_req_ready = !reset &&
                         ((r_state == ST_IDLE) ||
                          (r_wr_valid && bus.wr_ready && r_wr_last));
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_beat_done = r_wr_valid && bus.wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_last  <= 1'b0;
            r_wr_addr  <= 29'd0;
            r_wr_data  <= 64'd0;
            r_wr_bwe   <= 8'd0;
            r_err      <= 1'b0;
`ifdef STORE_FMT_SPLIT_EN
            r_b1_addr  <= 29'd0;
            r_b1_data  <= 64'd0;
            r_b1_bwe   <= 8'd0;
`endif
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                if (w_illegal) begin
                    // Consumed but dropped; any beat being handed off this
                    // edge was the last one, so the output goes empty.
                    r_err      <= 1'b1;
                    r_wr_valid <= 1'b0;
                    r_wr_last  <= 1'b0;
                    r_state    <= ST_IDLE;
                end else begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= bus.req_addr[31:3];
                    r_wr_data  <= w_b0_data;
                    r_wr_bwe   <= w_b0_bwe;
                    r_state    <= ST_BEAT0;
`ifdef STORE_FMT_SPLIT_EN
                    r_wr_last  <= !w_cross;
                    r_b1_addr  <= bus.req_addr[31:3] + 29'd1;
                    r_b1_data  <= w_b1_data;
                    r_b1_bwe   <= w_b1_bwe;
`else
                    r_wr_last  <= 1'b1;
`endif
                end
            end else if (w_beat_done) begin
`ifdef STORE_FMT_SPLIT_EN
                if (r_state == ST_BEAT0 && !r_wr_last) begin
                    r_wr_addr <= r_b1_addr;
                    r_wr_data <= r_b1_data;
                    r_wr_bwe  <= r_b1_bwe;
                    r_wr_last <= 1'b1;
                    r_state   <= ST_BEAT1;
                end else begin
                    r_wr_valid <= 1'b0;
                    r_wr_last  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
`else
                r_wr_valid <= 1'b0;
                r_wr_last  <= 1'b0;
                r_state    <= ST_IDLE;
`endif
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_last   = r_wr_last;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_bwe    = r_wr_bwe;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
